// File: rtl/shift_pkg.sv
// Types and defaults shared by the shift serializer and the shift_rx receiver.
package shift_pkg;

  typedef enum logic {
    RECV = 1'b0,
    HUNT = 1'b1
  } rx_state_t;

  localparam int SHIFT_DEFAULT_BITS = 8;

endpackage

// File: rtl/shift_rx_bitcnt.sv
// Frame bit counter for shift_rx: clear has priority over enable; last flags the
// final bit position of a frame (cnt == last_val).
module shift_rx_bitcnt #(
  parameter int width    = 4,
  parameter int last_val = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [width-1:0] cnt;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + width'(1);
  end

  assign last = (cnt == width'(last_val));

endmodule

// File: rtl/shift_rx.sv
// Serial-to-parallel receiver (MSB first, end-of-shift framed) with valid/ready output.
// Define SHIFT_RX_PARITY_EN to append and check one even-parity bit per frame.
module shift_rx
  import shift_pkg::*;
#(
  parameter int bits = SHIFT_DEFAULT_BITS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic            ser_in,
  input  logic            ser_eos,
  output logic [bits-1:0] dout,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic            frame_err,
  output logic            overrun,
  output logic            parity_err
);

`ifdef SHIFT_RX_PARITY_EN
  localparam int frame_len = bits + 1;
`else
  localparam int frame_len = bits;
`endif
  localparam int cnt_w = $clog2(bits + 1);

  rx_state_t       state;
  logic [bits-1:0] sreg;
  logic [bits-1:0] word;
  logic            last;
  logic            recv;
  logic            good;
  logic            bad_frame;
  logic            par_ok;
  logic            shift_en;
  logic            cnt_clr;
  logic            transfer;

  assign recv      = ena && (state == RECV);
  assign good      = recv && last && ser_eos;
  assign bad_frame = recv && (last != ser_eos);
  assign transfer  = dout_valid && dout_ready;

  // Restart the count at every frame boundary, good or bad, and on realignment.
  assign cnt_clr = ena && ((state == HUNT) ? ser_eos : (ser_eos || last));

`ifdef SHIFT_RX_PARITY_EN
  // The parity bit is checked against the data already held in sreg, never shifted in.
  assign word     = sreg;
  assign par_ok   = ~(^sreg ^ ser_in);
  assign shift_en = recv && !last;
`else
  assign word     = {sreg[bits-2:0], ser_in};
  assign par_ok   = 1'b1;
  assign shift_en = recv;
`endif

  shift_rx_bitcnt #(
    .width   (cnt_w),
    .last_val(frame_len - 1)
  ) u_bitcnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (recv),
    .last(last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RECV;
      sreg       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (shift_en)
        sreg <= {sreg[bits-2:0], ser_in};

      if (ena) begin
        case (state)
          RECV: if (bad_frame) begin
            frame_err <= 1'b1;
            state     <= HUNT;
          end
          HUNT: if (ser_eos) state <= RECV;
          default: state <= HUNT;
        endcase
      end

      // A same-cycle transfer frees the output register for the incoming word.
      if (good && par_ok && (!dout_valid || dout_ready)) begin
        dout       <= word;
        dout_valid <= 1'b1;
      end else begin
        if (good && par_ok)
          overrun <= 1'b1;
        if (transfer)
          dout_valid <= 1'b0;
      end
    end
  end

`ifdef SHIFT_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      parity_err <= 1'b0;
    else
      parity_err <= good && !par_ok;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_rx.sv
// Directed bench for shift_rx (bits=8): a scoreboard queue of expected words is
// drained by a monitor on every output transfer; flags are checked inline.
module tb_shift_rx;

`ifdef SHIFT_RX_PARITY_EN
  localparam int frame_len = 9;
`else
  localparam int frame_len = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic       ser_in = 1'b0;
  logic       ser_eos = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b1;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];

  shift_rx #(.bits(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .ser_in    (ser_in),
    .ser_eos   (ser_eos),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens at the next rising edge whenever valid & ready.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst && dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h expected none", dout);
        end else begin
          e = exp_q.pop_front();
          check("scoreboard_dout", 32'(dout), 32'(e));
        end
      end
    end
  end

  // One serial bit per cycle; ena drops after the edge so idle gaps freeze the receiver.
  task automatic send_bit(input logic b, input logic eos);
    ena     = 1'b1;
    ser_in  = b;
    ser_eos = eos;
    @(posedge clk);
    #1;
    ena     = 1'b0;
    ser_eos = 1'b0;
  endtask

  task automatic send_word_par(input logic [7:0] w, input logic p);
    for (int i = 7; i >= 0; i--) send_bit(w[i], 1'b0);
    send_bit(p, 1'b1);
  endtask

  task automatic send_word(input logic [7:0] w);
`ifdef SHIFT_RX_PARITY_EN
    send_word_par(w, ^w);
`else
    for (int i = 7; i >= 0; i--) send_bit(w[i], i == 0);
`endif
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1;
    dout_ready = v;
  endtask

  initial begin
    // Reset values
    @(negedge clk);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_valid", 32'(dout_valid), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: single word, valid exactly one cycle after the last bit
    exp_q.push_back(8'hA5);
    send_word(8'hA5);
    @(negedge clk);
    check("t1_valid", 32'(dout_valid), 32'h1);
    check("t1_dout", 32'(dout), 32'hA5);
    @(negedge clk);
    check("t1_valid_fall", 32'(dout_valid), 32'h0);

    // 2: overrun with consumer stalled
    set_ready(1'b0);
    exp_q.push_back(8'h3C);
    send_word(8'h3C);
    @(negedge clk);
    check("t2_no_overrun_yet", 32'(overrun), 32'h0);
    send_word(8'hC3);
    @(negedge clk);
    check("t2_overrun", 32'(overrun), 32'h1);
    check("t2_dout_held", 32'(dout), 32'h3C);
    check("t2_valid_held", 32'(dout_valid), 32'h1);
    set_ready(1'b1);
    @(negedge clk);
    @(negedge clk);
    check("t2_valid_fall", 32'(dout_valid), 32'h0);
    check("t2_overrun_sticky", 32'(overrun), 32'h1);

    // 3: early strobe, realign, good frame, then missing strobe
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    @(negedge clk);
    check("t3_frame_err", 32'(frame_err), 32'h1);
    check("t3_no_valid", 32'(dout_valid), 32'h0);
    @(negedge clk);
    check("t3_frame_err_pulse", 32'(frame_err), 32'h0);
    send_bit(1'b1, 1'b1);
    exp_q.push_back(8'h81);
    send_word(8'h81);
    @(negedge clk);
    check("t3_dout", 32'(dout), 32'h81);
    for (int i = 0; i < frame_len; i++) send_bit(1'b1, 1'b0);
    @(negedge clk);
    check("t3_missing_eos", 32'(frame_err), 32'h1);
    check("t3_missing_no_valid", 32'(dout_valid), 32'h0);
    send_bit(1'b0, 1'b1);

    // 4: reset mid-frame clears outputs immediately
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check("t4_rst_dout", 32'(dout), 32'h0);
    check("t4_rst_overrun", 32'(overrun), 32'h0);
    check("t4_rst_valid", 32'(dout_valid), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.push_back(8'h5A);
    send_word(8'h5A);
    @(negedge clk);
    check("t4_dout", 32'(dout), 32'h5A);

    // 5: ena low mid-frame with noise and strobes on the inputs
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      ser_in  = 1'b1;
      ser_eos = 1'b1;
      @(posedge clk);
      #1;
    end
    ser_eos = 1'b0;
    exp_q.push_back(8'h96);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
`ifdef SHIFT_RX_PARITY_EN
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
`else
    send_bit(1'b0, 1'b1);
`endif
    @(negedge clk);
    check("t5_dout", 32'(dout), 32'h96);
    check("t5_no_frame_err", 32'(frame_err), 32'h0);

    // Transfer still completes while ena is low
    set_ready(1'b0);
    exp_q.push_back(8'h0F);
    send_word(8'h0F);
    set_ready(1'b1);
    @(negedge clk);
    @(negedge clk);
    check("t5_ena0_transfer", 32'(dout_valid), 32'h0);
    check("t5_dout_kept", 32'(dout), 32'h0F);

`ifdef SHIFT_RX_PARITY_EN
    // 6: even parity accepted, then rejected
    exp_q.push_back(8'hA5);
    send_word_par(8'hA5, 1'b0);
    @(negedge clk);
    check("t6_par_ok_valid", 32'(dout_valid), 32'h1);
    check("t6_par_ok_err", 32'(parity_err), 32'h0);
    @(negedge clk);
    send_word_par(8'hA5, 1'b1);
    @(negedge clk);
    check("t6_parity_err", 32'(parity_err), 32'h1);
    check("t6_no_valid", 32'(dout_valid), 32'h0);
    @(negedge clk);
    check("t6_parity_pulse", 32'(parity_err), 32'h0);
`else
    check("parity_err_tied", 32'(parity_err), 32'h0);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
